// File: rtl/if_pkg.sv
// if_pkg: shared constants and FSM encoding for the instruction-fetch stage controller.
package if_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_INC    = 32'd4;
    typedef enum logic {RUN = 1'b0, PEND = 1'b1} if_state_t;
endpackage

// File: rtl/if_perf_counter.sv
// if_perf_counter: 32-bit wrapping enable counter with asynchronous active-low reset.
module if_perf_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [31:0] count
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else if (en) count <= count + 32'd1;
    end
endmodule

// File: rtl/if_stage_ctrl.sv
// if_stage_ctrl: PC, IF/ID register, parked-redirect FSM and stall watchdog.
// Define IF_PERF_CNT_EN to build the stall/flush performance counters.
module if_stage_ctrl
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MAX_STALL = 7
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        PCWrite,
    input  logic        IFID_Write,
    input  logic        IF_Flush,
    input  logic        Redirect_Valid,
    input  logic [31:0] Redirect_PC,
    input  logic [31:0] Instr_In,
    output logic [31:0] PC_Out,
    output logic [31:0] IFID_Instr,
    output logic [31:0] IFID_PCPlus4,
    output logic        IFID_Valid,
    output logic        Redirect_Pending,
    output logic        Stall_Timeout,
    output logic [31:0] Stall_Cycles,
    output logic [31:0] Flush_Cycles
);
    localparam logic [3:0] WD_MAX = 4'(MAX_STALL);

    if_state_t   state, state_next;
    logic [31:0] pend_pc, pend_next, pc_next, redir_pc;
    logic [3:0]  wd, wd_next;

    assign redir_pc = Redirect_PC & ~32'h3;

    // The youngest redirect always wins; a parked one only matters if nothing newer arrives.
    always_comb begin
        state_next = state;
        pend_next  = pend_pc;
        pc_next    = PC_Out;
        if (PCWrite) begin
            pc_next    = Redirect_Valid ? redir_pc : (state == PEND ? pend_pc : PC_Out + PC_INC);
            state_next = RUN;
        end else if (Redirect_Valid) begin
            pend_next  = redir_pc;
            state_next = PEND;
        end
    end

    assign wd_next = PCWrite ? 4'd0 : (wd == WD_MAX ? wd : wd + 4'd1);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state         <= RUN;
            pend_pc       <= '0;
            PC_Out        <= RESET_PC;
            wd            <= '0;
            Stall_Timeout <= 1'b0;
        end else begin
            state         <= state_next;
            pend_pc       <= pend_next;
            PC_Out        <= pc_next;
            wd            <= wd_next;
            Stall_Timeout <= Stall_Timeout | (wd_next == WD_MAX);
        end
    end

    // Flush squashes the instruction but keeps the PC+4 of the slot.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            IFID_Instr   <= '0;
            IFID_PCPlus4 <= '0;
            IFID_Valid   <= 1'b0;
        end else if (IF_Flush) begin
            IFID_Instr <= NOP_INSTR;
            IFID_Valid <= 1'b0;
        end else if (IFID_Write) begin
            IFID_Instr   <= Instr_In;
            IFID_PCPlus4 <= PC_Out + PC_INC;
            IFID_Valid   <= 1'b1;
        end
    end

    assign Redirect_Pending = (state == PEND);

`ifdef IF_PERF_CNT_EN
    if_perf_counter u_stall_cnt (.clk(Clk), .rst_n(Rst_n), .en(!PCWrite), .count(Stall_Cycles));
    if_perf_counter u_flush_cnt (.clk(Clk), .rst_n(Rst_n), .en(IF_Flush), .count(Flush_Cycles));
`else
    assign Stall_Cycles = '0;
    assign Flush_Cycles = '0;
`endif
endmodule

// File: doc/if_stage_ctrl.md
# if_stage_ctrl

Instruction-fetch stage controller: owns the program counter and the IF/ID pipeline register and acts on the hold/flush controls produced by the hazard detection unit. It sits between instruction memory and the decode stage. It holds, advances, redirects or flushes fetch each cycle, and parks redirects that arrive while fetch is stalled. A stall watchdog and optional performance counters expose pipeline health.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- MAX_STALL, 7, consecutive PCWrite=0 cycles that trip the watchdog (≥1, fits in 4 bits)

Ports:
- Clk  in  1  clock, rising edge
- Rst_n  in  1  reset, asynchronous, active-low
- PCWrite  in  1  1 = PC may update this cycle
- IFID_Write  in  1  1 = IF/ID register may load this cycle
- IF_Flush  in  1  1 = squash IF/ID contents (insert NOP)
- Redirect_Valid  in  1  branch/jump taken, new target supplied
- Redirect_PC  in  32  target address; bits [1:0] ignored (forced 0)
- Instr_In  in  32  instruction read combinationally from imem at PC_Out
- PC_Out  out  32  current fetch address
- IFID_Instr  out  32  decode-stage instruction
- IFID_PCPlus4  out  32  PC+4 of IFID_Instr
- IFID_Valid  out  1  IFID_Instr is a real instruction
- Redirect_Pending  out  1  a redirect is parked awaiting PCWrite
- Stall_Timeout  out  1  sticky watchdog flag
- Stall_Cycles  out  32  perf counter (see Configuration)
- Flush_Cycles  out  32  perf counter (see Configuration)

## Operation
- FSM states: RUN (no pending redirect), PEND (redirect parked).
- RUN: Redirect_Valid & !PCWrite → capture Redirect_PC into pend_pc, go PEND. Otherwise stay RUN.
- PEND: PCWrite=1 → PC loads pend_pc (or Redirect_PC if Redirect_Valid same cycle: youngest redirect wins), go RUN. PCWrite=0 & Redirect_Valid → overwrite pend_pc, stay PEND.
- Next PC when PCWrite=1, priority: Redirect_Valid → Redirect_PC&~3; PEND → pend_pc; else PC+4 (mod 2^32, wraps FFFF_FFFC→0000_0000). PCWrite=0 → PC holds.
- IF/ID priority: IF_Flush=1 → IFID_Instr=NOP (32'h0), IFID_Valid=0, IFID_PCPlus4 unchanged, regardless of IFID_Write. Else IFID_Write=1 → load Instr_In, PC_Out+4, Valid=1. Else hold all three.
- Watchdog: 4-bit counter increments each cycle PCWrite=0, clears when PCWrite=1, saturates at MAX_STALL. Reaching MAX_STALL sets Stall_Timeout; it stays set until reset. Watchdog does not force release.
- Redirect_Pending = (state==PEND).

## Timing
- All outputs registered, except Redirect_Pending (decoded from state register).
- Reset (async assert, sync-safe release): PC_Out=RESET_PC, IFID_Instr=0, IFID_PCPlus4=0, IFID_Valid=0, state=RUN, pend_pc=0, watchdog=0, Stall_Timeout=0, counters=0.
- Latency: PC_Out change → matching IFID_Instr visible one cycle later (imem read is combinational within the cycle).
- Redirect with PCWrite=1: PC_Out=target next cycle. Redirect with PCWrite=0: visible on the edge after PCWrite returns to 1.
- Simultaneous IF_Flush & IFID_Write=0: flush wins. Simultaneous Redirect_Valid & PEND & PCWrite=1: new target wins, pend cleared.
- Reset mid-stall or mid-PEND: parked redirect discarded; fetch restarts at RESET_PC.

## Configuration
- IF_PERF_CNT_EN defined: Stall_Cycles counts cycles with PCWrite=0. Flush_Cycles counts cycles with IF_Flush=1. Both are 32-bit and wrap at 2^32.
- Undefined: no counter flops; Stall_Cycles and Flush_Cycles tied to 0.

## Structure
- Package if_pkg: NOP_INSTR (32'h0), FSM state encoding (RUN, PEND), PC increment constant (4).
- One sub-module: if_perf_counter (32-bit enable-counter with async active-low reset), instantiated twice only under IF_PERF_CNT_EN.

## Test plan
- Reset release, PCWrite=IFID_Write=1 for 4 cycles, Instr_In=0xA0+PC → PC_Out 0,4,8,C; IFID_Instr lags one cycle, IFID_Valid=1 from cycle 2.
- PCWrite=IFID_Write=0 for 3 cycles at PC=0x10 → PC_Out and IFID_* frozen; Stall_Cycles +3 (macro on); Stall_Timeout stays 0.
- Redirect_Valid, Redirect_PC=0x203 while PCWrite=0 → Redirect_Pending=1; on PCWrite=1, PC_Out=0x200 next cycle, pending clears.
- IF_Flush=1 with IFID_Write=0 → IFID_Instr=0, IFID_Valid=0 next cycle; Flush_Cycles +1.
- PCWrite=0 held 7 cycles (MAX_STALL=7) → Stall_Timeout=1 and remains 1 after PCWrite=1; cleared only by Rst_n=0.
- PC=0xFFFF_FFFC, PCWrite=1 → PC_Out wraps to 0x0000_0000; Rst_n asserted mid-PEND → PC_Out=RESET_PC, Redirect_Pending=0 immediately.
